// File: rtl/xor_74x86_3_pkg.sv
// xor_74x86_3_pkg
//   Shared constants for the xor_74x86_3 slice: the default gate count,
//   the architecture selector values, and the single-gate XOR helper that
//   the per-gate sub-module uses.
//   No ports (package).
package xor_74x86_3_pkg;

  localparam int XOR_DEFAULT_WIDTH = 3;

  // Architecture selector values for the SPLIT parameter.
  localparam int XOR_ARCH_VEC   = 0;
  localparam int XOR_ARCH_SPLIT = 1;

  // One 2-input XOR gate. The ^ operator keeps X/Z local to this bit.
  function automatic logic xor_bit(input logic a, input logic b);
    return a ^ b;
  endfunction

endpackage

// File: rtl/xor_74x86_gate.sv
// xor_74x86_gate
//   One 2-input XOR gate (combinational only). This is the building block
//   for the split architecture of xor_74x86_3.
//   Ports:
//     a : gate input A
//     b : gate input B
//     y : a ^ b
module xor_74x86_gate
  import xor_74x86_3_pkg::*;
(
  input  logic a,
  input  logic b,
  output logic y
);

  assign y = xor_bit(a, b);

endmodule

// File: rtl/xor_74x86_3.sv
// xor_74x86_3
//   WIDTH independent 2-input XOR gates (74x86 style) with a combinational
//   result Y and a registered copy Y_Q for synchronous consumers.
//   SPLIT = 0 computes Y with one vector XOR.
//   SPLIT = 1 computes Y with WIDTH xor_74x86_gate instances.
//   Both architectures feed the same Y_Q register.
//   Ports:
//     clk : rising-edge clock for Y_Q
//     rst : synchronous active-high reset of Y_Q
//     A   : gate inputs A, [0:WIDTH-1], bit 0 is the leftmost literal bit
//     B   : gate inputs B, [0:WIDTH-1]
//     Y   : combinational A ^ B; it has no reset and ignores clk and rst
//     Y_Q : A ^ B registered on the rising edge; it is zero after reset
module xor_74x86_3
  import xor_74x86_3_pkg::*;
#(
  parameter int WIDTH = XOR_DEFAULT_WIDTH,
  parameter int SPLIT = XOR_ARCH_VEC
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [0:WIDTH-1] A,
  input  logic [0:WIDTH-1] B,
  output logic [0:WIDTH-1] Y,
  output logic [0:WIDTH-1] Y_Q
);

  logic [0:WIDTH-1] y_s;
  logic [0:WIDTH-1] y_q_r;

  generate
    if (SPLIT == XOR_ARCH_SPLIT) begin : g_split
      for (genvar i = 0; i < WIDTH; i++) begin : g_gate
        xor_74x86_gate u_gate (
          .a (A[i]),
          .b (B[i]),
          .y (y_s[i])
        );
      end
    end else begin : g_vec
      assign y_s = A ^ B;
    end
  endgenerate

  assign Y = y_s;

  // Registered copy of the XOR result. Reset clears it to zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      y_q_r <= {WIDTH{1'b0}};
    end else begin
      y_q_r <= y_s;
    end
  end

  assign Y_Q = y_q_r;

endmodule

// xor_74x86_3_vec
//   Thin wrapper that fixes the vectorised architecture (SPLIT = 0).
//   The ports are the same as on xor_74x86_3.
module xor_74x86_3_vec
  import xor_74x86_3_pkg::*;
#(
  parameter int WIDTH = XOR_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [0:WIDTH-1] A,
  input  logic [0:WIDTH-1] B,
  output logic [0:WIDTH-1] Y,
  output logic [0:WIDTH-1] Y_Q
);

  xor_74x86_3 #(
    .WIDTH (WIDTH),
    .SPLIT (XOR_ARCH_VEC)
  ) u_core (
    .clk (clk),
    .rst (rst),
    .A   (A),
    .B   (B),
    .Y   (Y),
    .Y_Q (Y_Q)
  );

endmodule

// xor_74x86_3_split
//   Thin wrapper that fixes the per-gate architecture (SPLIT = 1).
//   The ports are the same as on xor_74x86_3.
module xor_74x86_3_split
  import xor_74x86_3_pkg::*;
#(
  parameter int WIDTH = XOR_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [0:WIDTH-1] A,
  input  logic [0:WIDTH-1] B,
  output logic [0:WIDTH-1] Y,
  output logic [0:WIDTH-1] Y_Q
);

  xor_74x86_3 #(
    .WIDTH (WIDTH),
    .SPLIT (XOR_ARCH_SPLIT)
  ) u_core (
    .clk (clk),
    .rst (rst),
    .A   (A),
    .B   (B),
    .Y   (Y),
    .Y_Q (Y_Q)
  );

endmodule

// File: tb/tb_xor_74x86_3.sv
// tb_xor_74x86_3
//   Self-checking bench that drives both architectures of xor_74x86_3 with
//   the same stimulus. Each output is compared against a reference model
//   built from gate truth tables.
module tb_xor_74x86_3;

  logic       clk;
  logic       rst;
  logic [0:2] a_s;
  logic [0:2] b_s;
  logic [0:2] y_vec_s;
  logic [0:2] yq_vec_s;
  logic [0:2] y_split_s;
  logic [0:2] yq_split_s;

  int n_compared;
  int n_mismatched;

  xor_74x86_3 #(.WIDTH(3), .SPLIT(0)) dut_vec (
    .clk (clk),
    .rst (rst),
    .A   (a_s),
    .B   (b_s),
    .Y   (y_vec_s),
    .Y_Q (yq_vec_s)
  );

  xor_74x86_3 #(.WIDTH(3), .SPLIT(1)) dut_split (
    .clk (clk),
    .rst (rst),
    .A   (a_s),
    .B   (b_s),
    .Y   (y_split_s),
    .Y_Q (yq_split_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: each gate's output is 1 when its two inputs differ.
  // The result is counted per bit from the inputs.
  function automatic logic [0:2] ref_xor(input logic [0:2] a, input logic [0:2] b);
    logic [0:2] r;
    for (int i = 0; i < 3; i++) begin
      r[i] = ((int'(a[i]) + int'(b[i])) % 2) == 1;
    end
    return r;
  endfunction

  task automatic check_val(input string tag, input logic [0:2] observed, input logic [0:2] expected);
    n_compared++;
    if (observed !== expected) begin
      n_mismatched++;
      $display("FAIL %s: got %b expected %b (A=%b B=%b rst=%b t=%0t)",
               tag, observed, expected, a_s, b_s, rst, $time);
    end
  endtask

  // One stimulus step: apply the inputs at the falling edge and check Y on
  // both designs before the clock. After the rising edge, check Y_Q against
  // its expected registered value.
  task automatic step(input logic [0:2] a, input logic [0:2] b, input logic r, input string tag);
    logic [0:2] exp_y;
    logic [0:2] exp_q;
    @(negedge clk);
    a_s = a;
    b_s = b;
    rst = r;
    exp_y = ref_xor(a, b);
    exp_q = r ? 3'b000 : exp_y;
    #2;
    check_val({tag, " Y vec"},   y_vec_s,   exp_y);
    check_val({tag, " Y split"}, y_split_s, exp_y);
    @(posedge clk);
    #1;
    check_val({tag, " Y_Q vec"},   yq_vec_s,   exp_q);
    check_val({tag, " Y_Q split"}, yq_split_s, exp_q);
    // Y does not depend on the clock, so it must still show the result.
    check_val({tag, " Y hold vec"}, y_vec_s, exp_y);
  endtask

  initial begin
    n_compared   = 0;
    n_mismatched = 0;
    rst = 1'b1;
    a_s = 3'b000;
    b_s = 3'b000;

    // Hold reset for one edge: Y_Q clears and Y still follows its inputs.
    step(3'b101, 3'b011, 1'b1, "reset");

    // Directed truth-table rows and per-gate independence cases.
    step(3'b111, 3'b111, 1'b0, "tt all ones");
    step(3'b000, 3'b111, 1'b0, "tt 000^111");
    step(3'b111, 3'b000, 1'b0, "tt 111^000");
    step(3'b000, 3'b000, 1'b0, "tt zeros");
    step(3'b101, 3'b011, 1'b0, "indep 101^011");
    step(3'b010, 3'b110, 1'b0, "indep 010^110");
    step(3'b110, 3'b011, 1'b0, "regpath 110^011");

    // Mid-run reset: Y_Q goes 111, then 000 under reset, then 111 again.
    step(3'b000, 3'b111, 1'b0, "midrst pre");
    step(3'b000, 3'b111, 1'b1, "midrst assert");
    step(3'b000, 3'b111, 1'b0, "midrst release");

    // Exhaustive sweep of all 64 (A, B) combinations.
    for (int i = 0; i < 64; i++) begin
      logic [5:0] v;
      v = i[5:0];
      step(v[5:3], v[2:0], 1'b0, "sweep");
    end

    // Random stimulus with an occasional reset cycle.
    for (int i = 0; i < 200; i++) begin
      logic [2:0] ra;
      logic [2:0] rb;
      logic       rr;
      ra = 3'($urandom_range(7, 0));
      rb = 3'($urandom_range(7, 0));
      rr = ($urandom_range(7, 0) == 0);
      step(ra, rb, rr, "random");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
